// File: rtl/trd_sched.sv
// trd_sched: per-cycle round-robin issue scheduler for the 8-thread barrel core, with per-thread
// OFF/RDY/MISS tracking and a minimum re-issue distance. Define TRD_SCHED_PERF_EN to add the
// perf_clr input and the saturating idle_cyc / miss_cyc counters.
module trd_sched #(
  parameter int NUM_TRD   = 8,
  parameter int ISSUE_GAP = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_TRD-1:0] trd_start,
  input  logic [NUM_TRD-1:0] trd_halt,
  input  logic               i_miss,
  input  logic [2:0]         i_miss_trd,
  input  logic               d_miss,
  input  logic [2:0]         d_miss_trd,
  input  logic               refill_done,
  input  logic [2:0]         refill_trd,
  input  logic               stall,
  output logic [2:0]         cur_trd,
  output logic               cur_vld,
  output logic [NUM_TRD-1:0] trd_rdy,
  output logic [NUM_TRD-1:0] trd_miss,
  output logic               all_off
`ifdef TRD_SCHED_PERF_EN
  ,
  input  logic               perf_clr,
  output logic [31:0]        idle_cyc,
  output logic [31:0]        miss_cyc
`endif
);
  localparam int CW = ISSUE_GAP > 1 ? $clog2(ISSUE_GAP) : 1;
  typedef enum logic [1:0] {OFF, RDY, MISS} st_e;
  st_e                r_st   [NUM_TRD];
  st_e                w_nxt  [NUM_TRD];
  logic [CW-1:0]      r_cool [NUM_TRD];
  logic [NUM_TRD-1:0] w_miss;
  logic [NUM_TRD-1:0] w_ref;
  logic [NUM_TRD-1:0] w_elig;
  logic [2:0]         r_ptr;
  logic [2:0]         w_win;
  logic               w_any;
  // per-thread event decode, next state (halt > miss > refill > start) and eligibility
  always_comb begin
    for (int t = 0; t < NUM_TRD; t++) begin
      w_miss[t] = (i_miss && i_miss_trd == 3'(t)) || (d_miss && d_miss_trd == 3'(t));
      w_ref[t]  = refill_done && refill_trd == 3'(t);
      w_nxt[t]  = trd_halt[t] ? OFF :
                  (w_miss[t] && r_st[t] == RDY) ? MISS :
                  (w_ref[t] && r_st[t] == MISS) ? RDY :
                  (trd_start[t] && r_st[t] == OFF) ? RDY : r_st[t];
      w_elig[t] = r_st[t] == RDY && r_cool[t] == '0 && !w_miss[t] && !trd_halt[t];
    end
  end
  // round-robin pick: scan downward so the smallest offset from r_ptr+1 overwrites last
  always_comb begin
    w_any = |w_elig;
    w_win = r_ptr;
    for (int i = NUM_TRD; i >= 1; i--)
      if (w_elig[3'(int'(r_ptr) + i)]) w_win = 3'(int'(r_ptr) + i);
  end
  // thread state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      for (int t = 0; t < NUM_TRD; t++) r_st[t] <= t == 0 ? RDY : OFF;
    else
      for (int t = 0; t < NUM_TRD; t++) r_st[t] <= w_nxt[t];
  end
  // issue register, rotation pointer and cooldown counters (cooldown keeps running under stall)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_trd <= '0;
      cur_vld <= 1'b0;
      r_ptr   <= 3'd7;
      for (int t = 0; t < NUM_TRD; t++) r_cool[t] <= '0;
    end else begin
      if (!stall) begin
        cur_vld <= w_any;
        if (w_any) begin
          cur_trd <= w_win;
          r_ptr   <= w_win;
        end
      end
      for (int t = 0; t < NUM_TRD; t++)
        r_cool[t] <= trd_halt[t] ? '0 :
                     (!stall && w_any && w_win == 3'(t)) ? CW'(ISSUE_GAP - 1) :
                     (r_cool[t] != '0) ? r_cool[t] - 1'b1 : '0;
    end
  end
  // status flags decoded straight from the state registers
  always_comb begin
    all_off = 1'b1;
    for (int t = 0; t < NUM_TRD; t++) begin
      trd_rdy[t]  = r_st[t] == RDY;
      trd_miss[t] = r_st[t] == MISS;
      all_off     = all_off && r_st[t] == OFF;
    end
  end
`ifdef TRD_SCHED_PERF_EN
  // saturating idle / miss cycle counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cyc <= '0;
      miss_cyc <= '0;
    end else if (perf_clr) begin
      idle_cyc <= '0;
      miss_cyc <= '0;
    end else begin
      if (!stall && !w_any && idle_cyc != '1) idle_cyc <= idle_cyc + 1'b1;
      if (|trd_miss && miss_cyc != '1) miss_cyc <= miss_cyc + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_trd_sched.sv
// tb_trd_sched: directed vectors for trd_sched (ISSUE_GAP=4); the driver queues hand-computed
// expectations per clock edge and a separate monitor pops and compares after each edge.
module tb_trd_sched;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] trd_start = '0, trd_halt = '0;
  logic       i_miss = 1'b0, d_miss = 1'b0, refill_done = 1'b0, stall = 1'b0;
  logic [2:0] i_miss_trd = '0, d_miss_trd = '0, refill_trd = '0;
  logic [2:0] cur_trd;
  logic       cur_vld, all_off;
  logic [7:0] trd_rdy, trd_miss;
`ifdef TRD_SCHED_PERF_EN
  logic        perf_clr = 1'b0;
  logic [31:0] idle_cyc, miss_cyc;
`endif

  typedef struct packed {
    logic       vld;
    logic [2:0] trd;
    logic [7:0] rdy;
    logic [7:0] miss;
    logic       off;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [2:0] seq_a [4] = '{3'd4, 3'd5, 3'd6, 3'd7};
  logic [2:0] seq_b [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
  logic [2:0] seq_c [5] = '{3'd4, 3'd6, 3'd7, 3'd0, 3'd3};

  trd_sched #(.NUM_TRD(8), .ISSUE_GAP(4)) dut (
    .clk(clk), .rst_n(rst_n), .trd_start(trd_start), .trd_halt(trd_halt),
    .i_miss(i_miss), .i_miss_trd(i_miss_trd), .d_miss(d_miss), .d_miss_trd(d_miss_trd),
    .refill_done(refill_done), .refill_trd(refill_trd), .stall(stall),
    .cur_trd(cur_trd), .cur_vld(cur_vld), .trd_rdy(trd_rdy), .trd_miss(trd_miss),
    .all_off(all_off)
`ifdef TRD_SCHED_PERF_EN
    , .perf_clr(perf_clr), .idle_cyc(idle_cyc), .miss_cyc(miss_cyc)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec%0d: got %h expected %h at %0t", nm, n_vec, act, exp, $time);
    end
  endtask

  task automatic cmp(input exp_t e);
    n_vec++;
    chk("cur_vld", 8'(cur_vld), 8'(e.vld));
    chk("cur_trd", 8'(cur_trd), 8'(e.trd));
    chk("trd_rdy", trd_rdy, e.rdy);
    chk("trd_miss", trd_miss, e.miss);
    chk("all_off", 8'(all_off), 8'(e.off));
  endtask

  // monitor: one queued expectation per clock edge, compared just after the edge
  initial forever begin
    @(posedge clk);
    #1;
    if (q.size() != 0) cmp(q.pop_front());
  end

  // miss/refill args are {valid, thread id}; called at a negedge, returns at the next negedge
  task automatic step(input logic [7:0] st, input logic [7:0] hl, input logic [3:0] im,
                      input logic [3:0] dm, input logic [3:0] rf, input logic sl,
                      input logic ev, input logic [2:0] et, input logic [7:0] er,
                      input logic [7:0] em, input logic eo);
    exp_t e;
    trd_start = st;  trd_halt = hl;  stall = sl;
    i_miss = im[3];  i_miss_trd = im[2:0];
    d_miss = dm[3];  d_miss_trd = dm[2:0];
    refill_done = rf[3];  refill_trd = rf[2:0];
    e = '{vld: ev, trd: et, rdy: er, miss: em, off: eo};
    q.push_back(e);
    @(negedge clk);
  endtask

  // asynchronous reset applied mid-cycle; outputs must be at reset values before any edge
  task automatic do_reset;
    exp_t e;
    trd_start = '0;  trd_halt = '0;  stall = 1'b0;
    i_miss = 1'b0;  d_miss = 1'b0;  refill_done = 1'b0;
    #2 rst_n = 1'b0;
    #1 e = '{vld: 1'b0, trd: 3'd0, rdy: 8'h01, miss: 8'h00, off: 1'b0};
    cmp(e);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset;
    // thread 0 alone: issues every 4th edge
    step(0, 0, 0, 0, 0, 0, 1, 0, 8'h01, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 8'h01, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 8'h01, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 8'h01, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 8'h01, 0, 0);
    do_reset;
    // start 1-7 with the first edge: rotation 0..7,0,1
    step(8'hFE, 0, 0, 0, 0, 0, 1, 0, 8'hFF, 0, 0);
    for (int k = 2; k <= 10; k++) step(0, 0, 0, 0, 0, 0, 1, 3'(k - 1), 8'hFF, 0, 0);
    // D-miss parks thread 3, rotation skips it
    step(0, 0, 0, 4'hB, 0, 0, 1, 3'd2, 8'hF7, 8'h08, 0);
    foreach (seq_a[i]) step(0, 0, 0, 0, 0, 0, 1, seq_a[i], 8'hF7, 8'h08, 0);
    // refill returns thread 3 to the rotation
    step(0, 0, 0, 0, 4'hB, 0, 1, 3'd0, 8'hFF, 8'h00, 0);
    foreach (seq_b[i]) step(0, 0, 0, 0, 0, 0, 1, seq_b[i], 8'hFF, 8'h00, 0);
    // stall freezes issue for 3 edges, then resumes at pointer+1
    repeat (3) step(0, 0, 0, 0, 0, 1, 1, 3'd4, 8'hFF, 8'h00, 0);
    step(0, 0, 0, 0, 0, 0, 1, 3'd5, 8'hFF, 8'h00, 0);
    // park thread 6 so it can be refilled in the combined cycle
    step(0, 0, 0, 4'hE, 0, 0, 1, 3'd7, 8'hBF, 8'h40, 0);
    step(0, 0, 0, 0, 0, 0, 1, 3'd0, 8'hBF, 8'h40, 0);
    // combined: I-miss 2, D-miss 5, refill 6, halt 1
    step(0, 8'h02, 4'hA, 4'hD, 4'hE, 0, 1, 3'd3, 8'hD9, 8'h24, 0);
    foreach (seq_c[i]) step(0, 0, 0, 0, 0, 0, 1, seq_c[i], 8'hD9, 8'h24, 0);
    // halt all, then restart only thread 7
    step(0, 8'hFF, 0, 0, 0, 0, 0, 3'd3, 8'h00, 8'h00, 1);
    step(0, 0, 0, 0, 0, 0, 0, 3'd3, 8'h00, 8'h00, 1);
    step(8'h80, 0, 0, 0, 0, 0, 0, 3'd3, 8'h80, 8'h00, 0);
    step(0, 0, 0, 0, 0, 0, 1, 3'd7, 8'h80, 8'h00, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 3'd7, 8'h80, 8'h00, 0);
    step(0, 0, 0, 0, 0, 0, 1, 3'd7, 8'h80, 8'h00, 0);
    step(0, 0, 0, 4'hF, 0, 0, 0, 3'd7, 8'h00, 8'h80, 0);
    // reset with thread 7 in MISS; a later refill to it is ignored
    do_reset;
    step(0, 0, 0, 0, 4'hF, 0, 1, 3'd0, 8'h01, 8'h00, 0);
    step(0, 0, 0, 0, 0, 0, 0, 3'd0, 8'h01, 8'h00, 0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/trd_sched.md
Name: trd_sched

Overview:
- Per-cycle thread scheduler for the 8-thread barrel core.
- Tracks each hardware thread's run state (off / ready / parked on cache miss) and picks the issuing thread by round-robin.
- Enforces a minimum re-issue distance per thread so pipeline hazards within a thread are avoided.
- Drives the cur_trd consumed by the PC selector and fetch stage.

Parameters:
- NUM_TRD, 8, number of hardware threads; fixed at 8 because thread IDs are 3 bits.
- ISSUE_GAP, 4, minimum number of cycles between two issues of the same thread; legal range 1..8, and 1 means no restriction.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- trd_start  input  8  per-thread pulse: OFF->RDY
- trd_halt  input  8  per-thread pulse: any state->OFF
- i_miss  input  1  I-cache miss for i_miss_trd
- i_miss_trd  input  3  thread ID of the I-miss
- d_miss  input  1  D-cache miss for d_miss_trd
- d_miss_trd  input  3  thread ID of the D-miss
- refill_done  input  1  miss serviced for refill_trd
- refill_trd  input  3  thread ID of the refill
- stall  input  1  pipeline stall; freezes issue
- cur_trd  output  3  issued thread ID (registered)
- cur_vld  output  1  cur_trd is a valid issue this cycle
- trd_rdy  output  8  per-thread state==RDY
- trd_miss  output  8  per-thread state==MISS
- all_off  output  1  every thread is OFF

Behaviour:
- Reset state:
  - thread 0 = RDY; threads 1-7 = OFF.
  - cur_trd=0, cur_vld=0.
  - rr_ptr=7, so thread 0 is searched first.
  - all cooldown counters=0.
  - trd_rdy=8'h01, trd_miss=0, all_off=0.
- Per-thread FSM states: OFF, RDY, MISS.
  - Transitions are evaluated on each clk edge.
  - Priority within a thread: halt > miss > refill > start.
  - halt: any -> OFF; cooldown cleared.
  - miss, when (i_miss & i_miss_trd==t) | (d_miss & d_miss_trd==t): RDY -> MISS. A miss to a thread already in MISS or OFF is ignored.
  - refill, when refill_done & refill_trd==t: MISS -> RDY. A refill in any other state is ignored.
  - start: OFF -> RDY. A start in any other state is ignored.
- Misses and refills aimed at different threads in the same cycle all apply. I-miss and D-miss to the same thread produce a single MISS.
- Eligibility: elig[t] = (state==RDY) & (cool[t]==0) & no miss/halt for t this cycle.
- Issue decision (combinational, registered into the outputs):
  - If !stall and any elig bit is set: winner = first eligible thread scanning rr_ptr+1, rr_ptr+2, ... mod 8.
  - Next cycle: cur_trd=winner, cur_vld=1, rr_ptr=winner, cool[winner]=ISSUE_GAP-1.
  - If !stall and no thread is eligible: cur_vld<=0; cur_trd and rr_ptr hold.
  - If stall: cur_trd, cur_vld and rr_ptr hold; no thread is issued.
- Cooldown:
  - every nonzero cool[t] decrements by 1 each cycle, including during stall.
  - a thread issued in cycle n is eligible again at cycle n+ISSUE_GAP at the earliest.
  - Counter width is $clog2(ISSUE_GAP); a 1-bit counter is used when ISSUE_GAP==1.
- Issue latency: a thread made RDY at edge k can appear on cur_trd at edge k+1 at the earliest.
- Wrap-around: rr_ptr=7 searches from thread 0.
- Halt of the currently issued thread: cur_vld drops to 0 at the next edge unless another thread wins that edge.
- trd_rdy, trd_miss and all_off are decoded directly from the state registers, with no extra latency.
- Asynchronous reset mid-operation returns everything to the reset state immediately. In-flight misses are forgotten; refills arriving after reset are ignored because the target thread is not in MISS.

Optional Feature:
- Macro: TRD_SCHED_PERF_EN.
- When defined, adds two outputs:
  - idle_cyc[31:0]: increments on every cycle with !stall and no eligible thread.
  - miss_cyc[31:0]: increments on every cycle with at least one thread in MISS.
  - Both counters saturate at 32'hFFFF_FFFF, reset to 0, and are cleared by an extra input perf_clr.
- When not defined: these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset, then idle with ISSUE_GAP=4 -> thread 0 only:
  - cur_trd=0 with cur_vld=1 at cycles 1, 5, 9, ...
  - cur_vld=0 at cycles 2-4.
- trd_start=8'hFE one cycle after reset, ISSUE_GAP=4 -> cur_trd sequence 0,1,2,...,7,0,1 with cur_vld constantly 1.
- All 8 threads RDY; d_miss=1, d_miss_trd=3 -> trd_miss=8'h08; thread 3 is skipped, giving the order ...,2,4,5...
  - Then refill_done with refill_trd=3 -> trd_miss=0, and thread 3 issues again when the rotation reaches it.
- stall held 3 cycles while 8 threads run -> cur_trd and cur_vld frozen.
  - After release, issue resumes at rr_ptr+1 with no thread skipped or duplicated.
- Same cycle: i_miss to thread 2, d_miss to thread 5, refill to thread 6 (in MISS), trd_halt[1]=1 ->
  - trd_miss bits {2,5} set and bit 6 cleared.
  - thread 1 is OFF.
  - the next issue skips threads 1, 2 and 5.
- trd_halt=8'hFF -> all_off=1 and cur_vld=0 one edge later.
  - Then trd_start=8'h80 -> cur_trd=7 with cur_vld=1 two edges after the start pulse.
